sb_ctrl: RTL and testbench

Controller for the single-clock store-buffer FIFO. Arbitrates N write requesters round-robin into the FIFO write port. Drains FIFO entries one at a time to a downstream bus using a req/ack handshake. Sits between the load/store pipeline ports and the data-bus interface; the FIFO instance is external and connected through the fifo_* ports.

---
 rtl/sb_ctrl.sv | 111 +++++++++++
 tb/tb_sb_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_ctrl.sv
// Store-buffer controller: round-robin write arbitration into an external FIFO
// and a one-entry-at-a-time drain to the data bus over a req/ack handshake.
module sb_ctrl #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ*DATA_WIDTH-1:0] data_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic [DATA_WIDTH-1:0]      fifo_wr_data_o,
    output logic                       fifo_wr_en_o,
    input  logic                       fifo_full_i,
    output logic                       fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data_i,
    input  logic                       fifo_empty_i,
    output logic                       bus_req_o,
    output logic [DATA_WIDTH-1:0]      bus_data_o,
    input  logic                       bus_ack_i,
    output logic                       idle_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;

    logic [1:0]            r_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic                  r_bus_req;
    logic [DATA_WIDTH-1:0] r_bus_data;

    logic [NREQ-1:0]       w_gnt;
    logic                  w_found;
    logic [PTR_W-1:0]      w_next_ptr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_pop;
    int                    w_idx;

    // Search upward from the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        w_gnt      = '0;
        w_found    = 1'b0;
        w_next_ptr = r_rr_ptr;
        w_idx      = 0;
        if (!rst && !fifo_full_i) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = int'(r_rr_ptr) + k;
                if (w_idx >= NREQ) w_idx = w_idx - NREQ;
                if (!w_found && req_i[w_idx[PTR_W-1:0]]) begin
                    w_gnt[w_idx[PTR_W-1:0]] = 1'b1;
                    w_found    = 1'b1;
                    w_next_ptr = (w_idx == NREQ - 1) ? '0 : PTR_W'(w_idx + 1);
                end
            end
        end
    end

    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_wr_data = data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pop from IDLE, or back-to-back on an accepted entry; never when empty.
    assign w_pop = !rst && !fifo_empty_i &&
                   ((r_state == S_IDLE) || ((r_state == S_REQ) && bus_ack_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_bus_req  <= 1'b0;
            r_bus_data <= '0;
        end else begin
            if (w_found) r_rr_ptr <= w_next_ptr;
            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty_i) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_bus_data <= fifo_rd_data_i;
                    r_bus_req  <= 1'b1;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        r_state   <= fifo_empty_i ? S_IDLE : S_LOAD;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o          = w_gnt;
    assign fifo_wr_en_o   = w_found;
    assign fifo_wr_data_o = w_wr_data;
    assign fifo_rd_en_o   = w_pop;
    assign bus_req_o      = r_bus_req;
    assign bus_data_o     = r_bus_data;
    assign idle_o         = (r_state == S_IDLE) && fifo_empty_i && !(|req_i);

endmodule

// File: tb/tb_sb_ctrl.sv
// Directed bench for sb_ctrl: arbitration vector table plus hand-written
// drain, latency, full-stall and reset sequences against a behavioural FIFO.
module tb_sb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_i = 2'b00;
    logic [63:0] data_i = '0;
    logic [1:0]  gnt_o;
    logic [31:0] fifo_wr_data_o;
    logic        fifo_wr_en_o;
    logic        fifo_full_i;
    logic        fifo_rd_en_o;
    logic [31:0] fifo_rd_data_i;
    logic        fifo_empty_i;
    logic        bus_req_o;
    logic [31:0] bus_data_o;
    logic        bus_ack_i = 1'b0;
    logic        idle_o;

    logic        v_full = 1'b0;
    logic        started = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    sb_ctrl #(.NREQ(2), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .data_i         (data_i),
        .gnt_o          (gnt_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .bus_req_o      (bus_req_o),
        .bus_data_o     (bus_data_o),
        .bus_ack_i      (bus_ack_i),
        .idle_o         (idle_o)
    );

    // Behavioural FIFO, depth 16, registered flags, read data one cycle after pop.
    logic [31:0] m_mem [16];
    logic [3:0]  m_wp, m_rp;
    logic [4:0]  m_cnt;
    logic [31:0] m_rd;
    logic        m_full, m_empty;

    assign m_full         = (m_cnt == 5'd16);
    assign m_empty        = (m_cnt == 5'd0);
    assign fifo_full_i    = m_full | v_full;
    assign fifo_empty_i   = m_empty;
    assign fifo_rd_data_i = m_rd;

    always @(posedge clk) begin
        if (rst) begin
            m_wp  <= '0;
            m_rp  <= '0;
            m_cnt <= '0;
            m_rd  <= '0;
        end else begin
            if (fifo_wr_en_o && !m_full) begin
                m_mem[m_wp] <= fifo_wr_data_o;
                m_wp <= m_wp + 4'd1;
            end
            if (fifo_rd_en_o && !m_empty) begin
                m_rd <= m_mem[m_rp];
                m_rp <= m_rp + 4'd1;
            end
            m_cnt <= m_cnt + 5'(fifo_wr_en_o && !m_full) - 5'(fifo_rd_en_o && !m_empty);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous invariants: at most one grant, never pop an empty FIFO.
    always @(negedge clk) begin
        if (started) begin
            chk("gnt_onehot0", 32'($countones(gnt_o) <= 1), 32'd1);
            chk("pop_when_empty", 32'(fifo_rd_en_o && fifo_empty_i), 32'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        req_i  = 2'b00;
        v_full = 1'b0;
        bus_ack_i = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        full;
        logic [1:0]  gnt;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] exp_d [3];
        logic [31:0] hold;
        int w, got, cyc, n;

        vecs[0]  = '{2'b00, 1'b0, 2'b00, 32'h0};
        vecs[1]  = '{2'b11, 1'b0, 2'b01, 32'h11};
        vecs[2]  = '{2'b11, 1'b0, 2'b10, 32'h22};
        vecs[3]  = '{2'b11, 1'b0, 2'b01, 32'h11};
        vecs[4]  = '{2'b11, 1'b0, 2'b10, 32'h22};
        vecs[5]  = '{2'b11, 1'b1, 2'b00, 32'h0};
        vecs[6]  = '{2'b10, 1'b0, 2'b10, 32'h22};
        vecs[7]  = '{2'b10, 1'b0, 2'b10, 32'h22};
        vecs[8]  = '{2'b01, 1'b0, 2'b01, 32'h11};
        vecs[9]  = '{2'b01, 1'b0, 2'b01, 32'h11};
        vecs[10] = '{2'b11, 1'b0, 2'b10, 32'h22};
        vecs[11] = '{2'b00, 1'b0, 2'b00, 32'h0};

        // Reset state
        do_reset;
        started = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_bus_data", bus_data_o, 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);

        // Arbitration table
        tick;
        data_i    = {32'h22, 32'h11};
        bus_ack_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_i  = vecs[i].req;
            v_full = vecs[i].full;
            #1;
            chk($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_wdata", i), fifo_wr_data_o, vecs[i].wdata);
            chk($sformatf("vec%0d_wr_en", i), 32'(fifo_wr_en_o), 32'(|vecs[i].gnt));
            tick;
        end

        // Single store latency with ack tied high
        do_reset;
        bus_ack_i = 1'b1;
        req_i  = 2'b01;
        data_i = {32'h0, 32'hDEADBEEF};
        #1;
        chk("lat_gnt", 32'(gnt_o), 32'd1);
        chk("lat_wdata", fifo_wr_data_o, 32'hDEADBEEF);
        tick;
        req_i = 2'b00;
        #1;
        chk("lat_t1_req", 32'(bus_req_o), 32'd0);
        chk("lat_t1_pop", 32'(fifo_rd_en_o), 32'd1);
        tick; #1;
        chk("lat_t2_req", 32'(bus_req_o), 32'd0);
        tick; #1;
        chk("lat_t3_req", 32'(bus_req_o), 32'd1);
        chk("lat_t3_data", bus_data_o, 32'hDEADBEEF);
        tick; #1;
        chk("lat_t4_req", 32'(bus_req_o), 32'd0);
        chk("lat_t4_idle", 32'(idle_o), 32'd1);

        // Full stall, then the pointed-to requester wins first
        do_reset;
        bus_ack_i = 1'b1;
        req_i  = 2'b01;
        data_i = {32'h88, 32'h77};
        #1;
        chk("full_pre_gnt", 32'(gnt_o), 32'd1);
        tick;
        req_i  = 2'b11;
        v_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_gnt", 32'(gnt_o), 32'd0);
            chk("full_wr_en", 32'(fifo_wr_en_o), 32'd0);
            tick;
        end
        v_full = 1'b0;
        #1;
        chk("full_release_gnt", 32'(gnt_o), 32'd2);
        chk("full_release_wdata", fifo_wr_data_o, 32'h88);
        tick;
        req_i = 2'b00;

        // Three entries drained with a four-cycle ack delay each
        do_reset;
        exp_d[0] = 32'hA1; exp_d[1] = 32'hB2; exp_d[2] = 32'hC3;
        req_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            data_i = {32'h0, exp_d[i]};
            #1;
            chk("q_gnt", 32'(gnt_o), 32'd1);
            tick;
        end
        req_i = 2'b00;
        w = 0; got = 0; cyc = 0; hold = '0;
        while (got < 3 && cyc < 200) begin
            bus_ack_i = 1'b0;
            if (bus_req_o) begin
                w++;
                if (w == 1) hold = bus_data_o;
                bus_ack_i = (w == 5);
            end
            #1;
            if (bus_req_o) begin
                chk("drain_stable", bus_data_o, hold);
                if (bus_ack_i) begin
                    chk("drain_order", bus_data_o, exp_d[got]);
                    got++;
                    w = 0;
                end else begin
                    chk("drain_no_early_pop", 32'(fifo_rd_en_o), 32'd0);
                end
            end
            tick;
            cyc++;
        end
        bus_ack_i = 1'b0;
        chk("drain_count", 32'(got), 32'd3);
        #1;
        chk("drain_idle", 32'(idle_o), 32'd1);
        tick;

        // Reset while a bus request is outstanding
        do_reset;
        req_i = 2'b01;
        data_i = {32'h0, 32'h55};
        tick;
        data_i = {32'h0, 32'h66};
        tick;
        req_i = 2'b00;
        n = 0;
        while (!bus_req_o && n < 20) begin
            tick;
            n++;
        end
        chk("rstmid_req_up", 32'(bus_req_o), 32'd1);
        chk("rstmid_fifo_nonempty", 32'(fifo_empty_i), 32'd0);
        rst = 1'b1;
        req_i = 2'b11;
        bus_ack_i = 1'b1;
        #1;
        chk("rstmid_gnt", 32'(gnt_o), 32'd0);
        chk("rstmid_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("rstmid_no_pop", 32'(fifo_rd_en_o), 32'd0);
        tick;
        req_i = 2'b00;
        bus_ack_i = 1'b0;
        #1;
        chk("rstmid_req_drop", 32'(bus_req_o), 32'd0);
        chk("rstmid_idle", 32'(idle_o), 32'd1);
        rst = 1'b0;
        req_i = 2'b11;
        #1;
        chk("rstmid_ptr0_gnt", 32'(gnt_o), 32'd1);
        tick;
        req_i = 2'b00;
        tick;

        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
